// File: rtl/uart_tx_word_serializer.sv
// rtl/uart_tx_word_serializer.sv - FIFO word to UART byte serializer; UART_TX_SER_CHECKSUM_EN adds a per-word XOR byte
module uart_tx_word_serializer #(
    parameter int DATA_W    = 32,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    input  logic              tx_done,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = ($clog2(BYTES + 1) > 1) ? $clog2(BYTES + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LOAD,
        ST_SEND,
        ST_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic              more_data;
`ifdef UART_TX_SER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
    logic              csum_sent_q, csum_sent_d;
`endif

    // Byte that goes out next is always taken from the same end of the word register.
    function automatic logic [7:0] first_byte(input logic [DATA_W-1:0] w);
        if (MSB_FIRST != 0) begin
            return w[DATA_W-1 -: 8];
        end else begin
            return w[7:0];
        end
    endfunction

    // Consumed byte leaves the register, the next one moves into its place.
    function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
        if (MSB_FIRST != 0) begin
            return w << 8;
        end else begin
            return w >> 8;
        end
    endfunction

    // idx counts data bytes already issued; it never passes BYTES.
    assign more_data = (idx_q < LAST_IDX);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: word in flight, byte index, outgoing byte, counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            word_q      <= '0;
            idx_q       <= '0;
            tx_data_q   <= 8'h00;
            word_cnt_q  <= '0;
`ifdef UART_TX_SER_CHECKSUM_EN
            csum_q      <= 8'h00;
            csum_sent_q <= 1'b0;
`endif
        end else begin
            word_q      <= word_d;
            idx_q       <= idx_d;
            tx_data_q   <= tx_data_d;
            word_cnt_q  <= word_cnt_d;
`ifdef UART_TX_SER_CHECKSUM_EN
            csum_q      <= csum_d;
            csum_sent_q <= csum_sent_d;
`endif
        end
    end

    // Next-state decode; tx_done only matters in WAIT, fifo_empty only in IDLE and at word end.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = ST_READ;
            ST_READ: state_d = ST_LOAD;
            ST_LOAD: state_d = ST_SEND;
            ST_SEND: state_d = ST_WAIT;
            ST_WAIT: begin
                if (tx_done) begin
                    if (more_data) begin
                        state_d = ST_SEND;
                    end
`ifdef UART_TX_SER_CHECKSUM_EN
                    else if (!csum_sent_q) begin
                        state_d = ST_SEND;
                    end
`endif
                    else if (!fifo_empty) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode and datapath updates; tx_data is loaded on entry to SEND and held afterwards.
    always_comb begin
        word_d      = word_q;
        idx_d       = idx_q;
        tx_data_d   = tx_data_q;
        word_cnt_d  = word_cnt_q;
`ifdef UART_TX_SER_CHECKSUM_EN
        csum_d      = csum_q;
        csum_sent_d = csum_sent_q;
`endif
        fifo_rd_en  = (state_q == ST_READ);
        tx_valid    = (state_q == ST_SEND);
        busy        = (state_q != ST_IDLE);
        case (state_q)
            ST_LOAD: begin
                word_d      = fifo_data;
                idx_d       = '0;
                tx_data_d   = first_byte(fifo_data);
`ifdef UART_TX_SER_CHECKSUM_EN
                csum_d      = 8'h00;
                csum_sent_d = 1'b0;
`endif
            end
            ST_SEND: begin
`ifdef UART_TX_SER_CHECKSUM_EN
                // The checksum byte itself is neither counted nor folded back in.
                if (!csum_sent_q) begin
                    idx_d  = idx_q + IDX_W'(1);
                    csum_d = csum_q ^ tx_data_q;
                end
`else
                idx_d = idx_q + IDX_W'(1);
`endif
            end
            ST_WAIT: begin
                if (tx_done) begin
                    if (more_data) begin
                        word_d    = shift_word(word_q);
                        tx_data_d = first_byte(shift_word(word_q));
                    end
`ifdef UART_TX_SER_CHECKSUM_EN
                    else if (!csum_sent_q) begin
                        tx_data_d   = csum_q;
                        csum_sent_d = 1'b1;
                    end
`endif
                    else begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign tx_data  = tx_data_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_uart_tx_word_serializer.sv
// tb/tb_uart_tx_word_serializer.sv - scoreboard bench for uart_tx_word_serializer (MSB-first and LSB-first instances)
`timescale 1ns/1ps
module tb_uart_tx_word_serializer;

    localparam int DATA_W = 32;
    localparam int BYTES  = DATA_W / 8;
`ifdef UART_TX_SER_CHECKSUM_EN
    localparam int NB_TX  = BYTES + 1;
`else
    localparam int NB_TX  = BYTES;
`endif
    localparam int CNT_A  = 2;
    localparam int CNT_B  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data = '0;
    logic              tx_done = 1'b0;

    logic              fifo_rd_en, tx_valid, busy;
    logic [7:0]        tx_data;
    logic [CNT_A-1:0]  word_cnt;
    logic              b_fifo_rd_en, b_tx_valid, b_busy;
    logic [7:0]        b_tx_data;
    logic [CNT_B-1:0]  b_word_cnt;

    always #5 clk = ~clk;

    uart_tx_word_serializer #(.DATA_W(DATA_W), .MSB_FIRST(1), .CNT_W(CNT_A)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en), .tx_done(tx_done), .tx_valid(tx_valid),
        .tx_data(tx_data), .busy(busy), .word_cnt(word_cnt)
    );

    uart_tx_word_serializer #(.DATA_W(DATA_W), .MSB_FIRST(0), .CNT_W(CNT_B)) dut_lsb (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(b_fifo_rd_en), .tx_done(tx_done), .tx_valid(b_tx_valid),
        .tx_data(b_tx_data), .busy(b_busy), .word_cnt(b_word_cnt)
    );

    // FIFO model: words stored in mem, popped on the MSB-first instance's strobe
    logic [DATA_W-1:0] mem [0:255];
    int n_pushed = 0;
    int n_popped = 0;
    assign fifo_empty = (n_pushed == n_popped);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= mem[n_popped[7:0]];
            n_popped  <= n_popped + 1;
        end
    end

    // UART responder: tx_done done_delay+1 cycles after tx_valid, plus optional spurious pulses
    int done_delay = 0;
    bit spur_en = 1'b0;
    int wait_left = 0;

    initial begin : responder
        bit fire;
        forever begin
            @(posedge clk);
            #1;
            fire = 1'b0;
            if (wait_left > 0) begin
                wait_left = wait_left - 1;
                fire = (wait_left == 0);
            end
            if (tx_valid) wait_left = done_delay + 1;
            if (!reset) begin
                wait_left = 0;
                fire = 1'b0;
            end
            tx_done = fire || (spur_en && (!busy || fifo_rd_en || tx_valid));
        end
    end

    // Scoreboard state
    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int cyc = 0;
    int byte_pos = 0;
    bit awaiting = 1'b0;
    int pop_cycle = -100;
    int done_cycle = -100;
    int expect_pop = -1;
    int idle_check = -1;
    int pop_idx = 0;
    int words_since_reset = 0;
    int words_total = 0;
    logic [7:0] hold_a = 8'h00;
    logic [7:0] hold_b = 8'h00;
    bit prev_reset = 1'b0;
    bit end_req = 1'b0;
    bit end_done = 1'b0;
    int stim_timeouts = 0;
    int exp_words = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors = vectors + 1;
        if (act != exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h), cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    // Expected bytes of one word: data bytes in wire order, then the XOR byte when enabled
    task automatic push_expected(input logic [DATA_W-1:0] w);
        logic [7:0] cs;
        logic [7:0] ba;
        logic [7:0] bb;
        cs = 8'h00;
        for (int k = 0; k < BYTES; k++) begin
            ba = 8'((w >> (8 * (BYTES - 1 - k))) & 'hFF);
            bb = 8'((w >> (8 * k)) & 'hFF);
            exp_a.push_back(ba);
            exp_b.push_back(bb);
            cs = cs ^ ba;
        end
        if (NB_TX > BYTES) begin
            exp_a.push_back(cs);
            exp_b.push_back(cs);
        end
    endtask

    // Monitor: samples on the falling edge, compares against queues and timing expectations
    initial begin : monitor
        bit exp_rd;
        bit done_ok;
        logic [7:0] bt;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (!prev_reset) begin
                check("reset_fifo_rd_en", int'(fifo_rd_en), 0);
                check("reset_tx_valid", int'(tx_valid), 0);
                check("reset_tx_data", int'(tx_data), 0);
                check("reset_busy", int'(busy), 0);
                check("reset_word_cnt", int'(word_cnt), 0);
                check("reset_b_tx_valid", int'(b_tx_valid), 0);
                check("reset_b_tx_data", int'(b_tx_data), 0);
                check("reset_b_busy", int'(b_busy), 0);
                check("reset_b_word_cnt", int'(b_word_cnt), 0);
            end else begin
                exp_rd = (cyc == expect_pop);
                check("fifo_rd_en", int'(fifo_rd_en), int'(exp_rd));
                check("b_fifo_rd_en", int'(b_fifo_rd_en), int'(exp_rd));
                check("word_cnt", int'(word_cnt), words_since_reset % (1 << CNT_A));
                check("b_word_cnt", int'(b_word_cnt), words_since_reset % (1 << CNT_B));
                if (cyc == idle_check) begin
                    check("idle_busy", int'(busy), 0);
                    check("idle_b_busy", int'(b_busy), 0);
                end
                if (fifo_rd_en) begin
                    check("pop_while_nonempty", int'(fifo_empty), 0);
                    pop_cycle = cyc;
                    if (!fifo_empty) begin
                        push_expected(mem[pop_idx[7:0]]);
                        pop_idx = pop_idx + 1;
                    end
                end
                if (tx_valid) begin
                    check("tx_valid_expected", int'(exp_a.size() != 0), 1);
                    if (exp_a.size() != 0) begin
                        bt = exp_a.pop_front();
                        check("tx_data", int'(tx_data), int'(bt));
                        hold_a = bt;
                    end
                    check("busy_while_sending", int'(busy), 1);
                    if (byte_pos == 0) check("first_byte_latency", cyc - pop_cycle, 2);
                    else check("byte_gap", cyc - done_cycle, 1);
                    byte_pos = byte_pos + 1;
                    awaiting = 1'b1;
                end else begin
                    check("tx_data_hold", int'(tx_data), int'(hold_a));
                end
                if (b_tx_valid) begin
                    check("b_tx_valid_expected", int'(exp_b.size() != 0), 1);
                    if (exp_b.size() != 0) begin
                        bt = exp_b.pop_front();
                        check("b_tx_data", int'(b_tx_data), int'(bt));
                        hold_b = bt;
                    end
                end else begin
                    check("b_tx_data_hold", int'(b_tx_data), int'(hold_b));
                end
                done_ok = tx_done && awaiting && !tx_valid;
                if (done_ok) begin
                    awaiting = 1'b0;
                    done_cycle = cyc;
                    if (byte_pos == NB_TX) begin
                        byte_pos = 0;
                        words_since_reset = words_since_reset + 1;
                        words_total = words_total + 1;
                        if (fifo_empty) idle_check = cyc + 1;
                        else expect_pop = cyc + 1;
                    end
                end
            end
            if (!busy && !fifo_empty && reset) expect_pop = cyc + 1;
            if (end_req && !end_done) begin
                check("exp_a_drained", exp_a.size(), 0);
                check("exp_b_drained", exp_b.size(), 0);
                check("final_busy", int'(busy), 0);
                check("final_b_busy", int'(b_busy), 0);
                check("words_completed", words_total, exp_words);
                check("stimulus_wait_timeouts", stim_timeouts, 0);
                end_done = 1'b1;
            end
            if (!reset) begin
                exp_a.delete();
                exp_b.delete();
                byte_pos = 0;
                awaiting = 1'b0;
                words_since_reset = 0;
                hold_a = 8'h00;
                hold_b = 8'h00;
                expect_pop = -1;
                idle_check = -1;
            end
            prev_reset = reset;
        end
    end

    task automatic align();
        @(posedge clk);
        #2;
    endtask

    task automatic push_now(input logic [DATA_W-1:0] w);
        mem[n_pushed[7:0]] = w;
        n_pushed = n_pushed + 1;
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        align();
        push_now(w);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            align();
            n = n + 1;
        end while (!(n_popped == n_pushed && !busy && !b_busy) && n < 3000);
        if (n >= 3000) stim_timeouts = stim_timeouts + 1;
        repeat (3) align();
    endtask

    // Stimulus
    initial begin : stimulus
        int n;
        int seen;
        reset = 1'b0;
        repeat (3) align();
        reset = 1'b1;
        repeat (2) align();

        // single known word, slow UART
        done_delay = 4;
        push(32'hA1B2C3D4);
        wait_idle();

        // three queued words, UART answers immediately
        done_delay = 0;
        align();
        for (int i = 0; i < 3; i++) push_now($urandom);
        wait_idle();

        // spurious tx_done in IDLE, READ and alongside tx_valid
        spur_en = 1'b1;
        done_delay = 2;
        push(32'h0F1E2D3C);
        wait_idle();
        push($urandom);
        push($urandom);
        wait_idle();
        spur_en = 1'b0;

        // reset while waiting after the second byte; the queued word must start cleanly
        done_delay = 3;
        align();
        push_now(32'h11223344);
        push_now(32'h55667788);
        seen = 0;
        n = 0;
        while (seen < 2 && n < 200) begin
            align();
            n = n + 1;
            if (tx_valid) seen = seen + 1;
        end
        if (seen < 2) stim_timeouts = stim_timeouts + 1;
        align();
        reset = 1'b0;
        repeat (2) align();
        reset = 1'b1;
        wait_idle();

        // randomized traffic; the 2-bit counter wraps along the way
        for (int i = 0; i < 8; i++) begin
            spur_en = bit'($urandom_range(0, 1));
            done_delay = $urandom_range(0, 4);
            repeat ($urandom_range(0, 20)) align();
            push($urandom);
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        spur_en = 1'b0;
        wait_idle();

        exp_words = 16;
        end_req = 1'b1;
        n = 0;
        while (!end_done && n < 10) begin
            align();
            n = n + 1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : time_limit
        #500000;
        $display("FAIL time_limit: simulation did not finish, vectors %0d miscompares %0d", vectors, miscompares);
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_word_serializer.md
# uart_tx_word_serializer

Parametrised FIFO-to-UART transmit connector that pops DATA_W-bit words from a synchronous FIFO and feeds them byte by byte to the UART transmitter using a valid/done handshake. It sits between the readback FIFO of the DDR3 test datapath and the UART TX core. It generalises the single-byte connector to arbitrary word widths, selectable byte order and a sent-word counter, with an optional per-word checksum byte.

## Interface
- DATA_W, 32, FIFO word width; multiple of 8, ≥ 8
- MSB_FIRST, 1, 1 = send bits [DATA_W-1 -: 8] first; 0 = send bits [7:0] first
- CNT_W, 16, width of sent-word counter
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- fifo_empty  in  1  FIFO empty flag
- fifo_data  in  DATA_W  FIFO read data, valid the cycle after fifo_rd_en
- fifo_rd_en  out  1  FIFO pop strobe, one-cycle pulse
- tx_done  in  1  UART one-cycle pulse: current byte fully shifted out
- tx_valid  out  1  one-cycle pulse: tx_data holds a new byte
- tx_data  out  8  byte to UART, held stable until next tx_valid
- busy  out  1  high in every state except IDLE
- word_cnt  out  CNT_W  words fully transmitted since reset

## Operation
- BYTES = DATA_W/8. Byte index counter width max(1, clog2(BYTES+1)).
- States: IDLE, READ, LOAD, SEND, WAIT.
- IDLE: if !fifo_empty → READ.
- READ: fifo_rd_en=1 for exactly this cycle → LOAD.
- LOAD: capture fifo_data into the word shift register; clear byte index and checksum → SEND.
- SEND: tx_valid=1; tx_data = current byte; XOR byte into checksum → WAIT.
- WAIT: hold until tx_done. On tx_done:
  - more data bytes remain → shift word by 8 (direction per MSB_FIRST), then SEND;
  - last data byte sent and checksum enabled → SEND checksum byte;
  - word complete → word_cnt+1 (wraps to 0 at 2^CNT_W), then READ if !fifo_empty, else IDLE.
- tx_done outside WAIT is ignored. A tx_done in the same cycle as tx_valid is not counted.
- fifo_empty is sampled only in IDLE and at word completion; it is never popped while empty.
- Reset mid-word: the word in flight is discarded, nothing is re-popped, all outputs return to reset values the next cycle.

## Timing
- Reset values: fifo_rd_en=0, tx_valid=0, tx_data=8'h00, busy=0, word_cnt=0, state IDLE.
- All outputs are registered or decoded from registered state; no combinational input-to-output path.
- Latency: !fifo_empty seen in IDLE at cycle N → fifo_rd_en at N+1 → capture at N+2 → first tx_valid at N+3.
- Byte-to-byte: tx_done at cycle M → next tx_valid at M+1.
- Back-to-back words: last tx_done at M → fifo_rd_en at M+1 → tx_valid at M+3.
- word_cnt updates in the cycle after the final tx_done of the word.

## Configuration
- Macro UART_TX_SER_CHECKSUM_EN.
- Defined: after the BYTES data bytes, one extra byte equal to the XOR of all data bytes of that word is sent with the same handshake. A word takes BYTES+1 tx_valid pulses, and word_cnt increments after the checksum byte's tx_done.
- Undefined: exactly BYTES bytes per word. The checksum logic is absent.

## Test plan
- DATA_W=32, MSB_FIRST=1, word 0xA1B2C3D4, tx_done 5 cycles after each tx_valid → bytes A1,B2,C3,D4. With the macro defined, a fifth byte 04 follows. word_cnt=1.
- Same word, MSB_FIRST=0 → bytes D4,C3,B2,A1. Checksum 04 when enabled.
- FIFO holds 3 words, tx_done answered immediately → exactly 3 fifo_rd_en pulses, 12 (or 15) tx_valid pulses, no pop while fifo_empty=1, word_cnt=3, busy drops, state IDLE.
- tx_done injected in IDLE, in READ, and in the same cycle as tx_valid → ignored. The byte sequence is unchanged.
- reset asserted in WAIT after byte 2 → all outputs at reset values next cycle. After release with the FIFO non-empty, the next word starts from byte 0 with a fresh pop.
- CNT_W=2, send 5 words → word_cnt sequence 1,2,3,0,1.
